// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency countdown, pending result
// committed on the final busy edge, and D-stage stall generation.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_d,
    input  logic        mf_hi,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;

    logic [63:0]      result_s;
    logic             is_md_op_s;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    function automatic logic [63:0] mul_signed(input logic [31:0] x, input logic [31:0] y);
        mul_signed = {{32{x[31]}}, x} * {{32{y[31]}}, y};
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] x, input logic [31:0] y);
        mul_unsigned = {32'h0000_0000, x} * {32'h0000_0000, y};
    endfunction

    // Returns {remainder, quotient}; a zero divisor is forced to one to keep the datapath defined.
    function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ys;
        ys = (y == 32'd0) ? 32'd1 : y;
        div_unsigned = {x % ys, x / ys};
    endfunction

    // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    function automatic logic [63:0] div_signed(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] xm;
        logic [31:0] ym;
        logic [31:0] q;
        logic [31:0] r;
        xm = x[31] ? (32'd0 - x) : x;
        ym = y[31] ? (32'd0 - y) : y;
        {r, q} = div_unsigned(xm, ym);
        if (x[31] ^ y[31]) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (x[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        div_signed = {r, q};
    endfunction

    // Candidate pending {hi, lo} for the op presented this cycle.
    always_comb begin
        result_s = {hi_r, lo_r};
        case (op)
            OP_MULT:  result_s = mul_signed(a, b);
            OP_MULTU: result_s = mul_unsigned(a, b);
            OP_DIV: begin
                if (b != 32'd0) begin
                    result_s = div_signed(a, b);
                end else begin
                    result_s = {hi_r, lo_r};
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    result_s = div_unsigned(a, b);
                end else begin
                    result_s = {hi_r, lo_r};
                end
            end
            default:  result_s = {hi_r, lo_r};
        endcase
    end

    // Decode of the ops that occupy the unit and therefore must stall D.
    always_comb begin
        is_md_op_s = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_md_op_s = 1'b1;
            default:                            is_md_op_s = 1'b0;
        endcase
    end

    // Sequencer: launch from IDLE, count down in RUN, commit on the last busy edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_r <= result_s[63:32];
                                pend_lo_r <= result_s[31:0];
                                cnt_r     <= MULT_LOAD;
                                state_r   <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_r <= result_s[63:32];
                                pend_lo_r <= result_s[31:0];
                                cnt_r     <= DIV_LOAD;
                                state_r   <= ST_RUN;
                            end
                            OP_MTHI: hi_r <= a;
                            OP_MTLO: lo_r <= a;
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == CNT_ONE) begin
                        hi_r    <= pend_hi_r;
                        lo_r    <= pend_lo_r;
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (cnt_r != '0);
    assign stall_md = md_d & (busy | (start & is_md_op_s));
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign md_out   = mf_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_d;
    logic        mf_hi;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    int          m_rem;

    muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_d(md_d), .mf_hi(mf_hi), .busy(busy), .stall_md(stall_md),
        .hi(hi), .lo(lo), .md_out(md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_rem = 0;
    endtask

    // Effect of one rising edge on the architectural model.
    task automatic model_edge();
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, up;
        if (m_rem == 0) begin
            if (start) begin
                case (op)
                    3'd1: begin
                        sx = longint'($signed(a)); sy = longint'($signed(b));
                        sq = sx * sy;
                        m_phi = sq[63:32]; m_plo = sq[31:0]; m_rem = MC;
                    end
                    3'd2: begin
                        ux = {32'd0, a}; uy = {32'd0, b}; up = ux * uy;
                        m_phi = up[63:32]; m_plo = up[31:0]; m_rem = MC;
                    end
                    3'd3: begin
                        if (b == 32'd0) begin
                            m_phi = m_hi; m_plo = m_lo;
                        end else begin
                            sx = longint'($signed(a)); sy = longint'($signed(b));
                            sq = sx / sy; sr = sx % sy;
                            m_phi = sr[31:0]; m_plo = sq[31:0];
                        end
                        m_rem = DC;
                    end
                    3'd4: begin
                        if (b == 32'd0) begin
                            m_phi = m_hi; m_plo = m_lo;
                        end else begin
                            m_phi = a % b; m_plo = a / b;
                        end
                        m_rem = DC;
                    end
                    3'd5: m_hi = a;
                    3'd6: m_lo = a;
                    default: ;
                endcase
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic s, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic md, input logic mh);
        logic e_busy;
        logic e_stall;
        @(negedge clk);
        start = s; op = o; a = av; b = bv; md_d = md; mf_hi = mh;
        #1;
        e_busy  = (m_rem != 0);
        e_stall = md & (e_busy | (s & (o >= 3'd1) & (o <= 3'd4)));
        chk("busy",   {31'd0, busy},     {31'd0, e_busy});
        chk("stall",  {31'd0, stall_md}, {31'd0, e_stall});
        chk("hi",     hi, m_hi);
        chk("lo",     lo, m_lo);
        chk("md_out", md_out, mh ? m_hi : m_lo);
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n, input logic md);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, md, i[0]);
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        #1;
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       pick = 32'd0;
            1:       pick = 32'hFFFF_FFFF;
            2:       pick = 32'h8000_0000;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_d = 1'b0; mf_hi = 1'b0;
        model_reset();
        #3;
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // mult -3 * 5
        step(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
        idle(MC, 1'b0);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // multu, div, divu sequence
        step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(MC, 1'b0);
        expect_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DC, 1'b0);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        step(1'b1, 3'd4, 32'd7, 32'd2, 1'b0, 1'b1);
        idle(DC, 1'b0);
        expect_hilo("divu", 32'd1, 32'd3);

        // stall window with md_d held high, then held low
        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        idle(DC + 1, 1'b1);
        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);

        // mthi/mtlo back to back, then div by zero leaves them intact
        step(1'b1, 3'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b1);
        step(1'b1, 3'd6, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        expect_hilo("mt", 32'h0000_1234, 32'h0000_5678);
        step(1'b1, 3'd3, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        idle(DC, 1'b0);
        expect_hilo("divz", 32'h0000_1234, 32'h0000_5678);
        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DC, 1'b0);
        expect_hilo("divovf", 32'd0, 32'h8000_0000);
        step(1'b1, 3'd5, 32'hAAAA_0000, 32'd0, 1'b0, 1'b1);
        step(1'b1, 3'd6, 32'h0000_BBBB, 32'd0, 1'b0, 1'b0);
        expect_hilo("mt2", 32'hAAAA_0000, 32'h0000_BBBB);

        // mthi while busy is ignored
        step(1'b1, 3'd2, 32'd3, 32'd4, 1'b0, 1'b0);
        step(1'b1, 3'd5, 32'h1111_1111, 32'd0, 1'b1, 1'b1);
        idle(MC - 1, 1'b0);
        expect_hilo("mthi_busy", 32'd0, 32'd12);

        // asynchronous reset in busy cycle 3 of a mult
        step(1'b1, 3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
        idle(2, 1'b0);
        @(negedge clk);
        start = 1'b0; md_d = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, busy},     32'd0);
        chk("arst_stall", {31'd0, stall_md}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(MC + 3, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(DC + 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
